// File: rtl/evm_result_uart_tx_if.sv
// Result interface between the vote counter side and the UART result transmitter.
// The master drives the snapshot inputs and start; the slave (transmitter) drives tx/busy/done.
interface evm_result_uart_tx_if;
    logic       start;
    logic [5:0] vote_party1;
    logic [5:0] vote_party2;
    logic [5:0] vote_party3;
    logic [5:0] vote_party4;
    logic [7:0] total_voting;
    logic [1:0] winner;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (
        output start, vote_party1, vote_party2, vote_party3, vote_party4,
               total_voting, winner,
        input  tx, busy, done
    );

    modport slave (
        input  start, vote_party1, vote_party2, vote_party3, vote_party4,
               total_voting, winner,
        output tx, busy, done
    );
endinterface

// File: rtl/evm_result_uart_tx.sv
// EVM result transmitter: snapshots vote counts on start and sends an 8-byte
// framed packet (header, 4 counts, total, winner, XOR checksum) as UART 8N1, LSB first.
module evm_result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    evm_result_uart_tx_if.slave  res_if
);

    localparam int unsigned    BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_BIT = 3'd1,
        S_DATA_BITS = 3'd2,
        S_STOP_BIT  = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t         r_state;
    logic [BW-1:0]  r_baud;
    logic [2:0]     r_bit_idx;
    logic [2:0]     r_byte_idx;
    logic [5:0]     r_p1;
    logic [5:0]     r_p2;
    logic [5:0]     r_p3;
    logic [5:0]     r_p4;
    logic [7:0]     r_total;
    logic [1:0]     r_winner;
    logic [7:0]     r_chk;
    logic           r_tx;
    logic           r_busy;
    logic           r_done;

    logic [7:0]     w_cur_byte;
    logic [2:0]     w_next_bit;
    logic           w_baud_end;

    // Checksum covers the payload bytes only; the header is excluded.
    function automatic logic [7:0] f_checksum(
        input logic [5:0] p1,
        input logic [5:0] p2,
        input logic [5:0] p3,
        input logic [5:0] p4,
        input logic [7:0] tot,
        input logic [1:0] win
    );
        return {2'b00, p1} ^ {2'b00, p2} ^ {2'b00, p3} ^ {2'b00, p4}
             ^ tot ^ {6'b000000, win};
    endfunction

    assign w_next_bit = r_bit_idx + 3'd1;
    assign w_baud_end = (r_baud == BAUD_LAST);

    // Select the byte currently being serialised from the snapshot.
    always_comb begin
        w_cur_byte = 8'h00;
        case (r_byte_idx)
            3'd0:    w_cur_byte = HEADER;
            3'd1:    w_cur_byte = {2'b00, r_p1};
            3'd2:    w_cur_byte = {2'b00, r_p2};
            3'd3:    w_cur_byte = {2'b00, r_p3};
            3'd4:    w_cur_byte = {2'b00, r_p4};
            3'd5:    w_cur_byte = r_total;
            3'd6:    w_cur_byte = {6'b000000, r_winner};
            3'd7:    w_cur_byte = r_chk;
            default: w_cur_byte = 8'h00;
        endcase
    end

    // Frame FSM; tx is loaded with the level of the bit that begins at each edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_baud     <= {BW{1'b0}};
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 3'd0;
            r_p1       <= 6'd0;
            r_p2       <= 6'd0;
            r_p3       <= 6'd0;
            r_p4       <= 6'd0;
            r_total    <= 8'd0;
            r_winner   <= 2'd0;
            r_chk      <= 8'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (res_if.start) begin
                        r_p1       <= res_if.vote_party1;
                        r_p2       <= res_if.vote_party2;
                        r_p3       <= res_if.vote_party3;
                        r_p4       <= res_if.vote_party4;
                        r_total    <= res_if.total_voting;
                        r_winner   <= res_if.winner;
                        r_chk      <= f_checksum(res_if.vote_party1, res_if.vote_party2,
                                                 res_if.vote_party3, res_if.vote_party4,
                                                 res_if.total_voting, res_if.winner);
                        r_baud     <= {BW{1'b0}};
                        r_bit_idx  <= 3'd0;
                        r_byte_idx <= 3'd0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START_BIT;
                    end else begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                S_START_BIT: begin
                    if (w_baud_end) begin
                        r_baud    <= {BW{1'b0}};
                        r_bit_idx <= 3'd0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= S_DATA_BITS;
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                S_DATA_BITS: begin
                    if (w_baud_end) begin
                        r_baud <= {BW{1'b0}};
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP_BIT;
                        end else begin
                            r_bit_idx <= w_next_bit;
                            r_tx      <= w_cur_byte[w_next_bit];
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                S_STOP_BIT: begin
                    if (w_baud_end) begin
                        r_baud <= {BW{1'b0}};
                        if (r_byte_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_byte_idx <= r_byte_idx + 3'd1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START_BIT;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_ONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign res_if.tx   = r_tx;
    assign res_if.busy = r_busy;
    assign res_if.done = r_done;

endmodule

// File: tb/tb_evm_result_uart_tx.sv
// Self-checking bench for evm_result_uart_tx: a frame-level model predicts the
// serial line bit by bit and the decoded bytes are compared against it.
module tb_evm_result_uart_tx;

    typedef logic [7:0] frame_t [8];

    logic       clk = 1'b0;
    logic       reset;
    logic       start16;
    logic       start2;
    logic [5:0] in_p1;
    logic [5:0] in_p2;
    logic [5:0] in_p3;
    logic [5:0] in_p4;
    logic [7:0] in_total;
    logic [1:0] in_winner;
    logic       use2;
    logic       m_tx;
    logic       m_busy;
    logic       m_done;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    evm_result_uart_tx_if if16 ();
    evm_result_uart_tx_if if2 ();

    assign if16.start        = start16;
    assign if16.vote_party1  = in_p1;
    assign if16.vote_party2  = in_p2;
    assign if16.vote_party3  = in_p3;
    assign if16.vote_party4  = in_p4;
    assign if16.total_voting = in_total;
    assign if16.winner       = in_winner;
    assign if2.start         = start2;
    assign if2.vote_party1   = in_p1;
    assign if2.vote_party2   = in_p2;
    assign if2.vote_party3   = in_p3;
    assign if2.vote_party4   = in_p4;
    assign if2.total_voting  = in_total;
    assign if2.winner        = in_winner;

    evm_result_uart_tx #(.CLKS_PER_BIT(16), .HEADER(8'hA5)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .res_if (if16.slave)
    );

    evm_result_uart_tx #(.CLKS_PER_BIT(2), .HEADER(8'hA5)) dut2 (
        .clk    (clk),
        .reset  (reset),
        .res_if (if2.slave)
    );

    assign m_tx   = use2 ? if2.tx   : if16.tx;
    assign m_busy = use2 ? if2.busy : if16.busy;
    assign m_done = use2 ? if2.done : if16.done;

    function automatic frame_t model_frame(input logic [5:0] a, input logic [5:0] b,
                                           input logic [5:0] c, input logic [5:0] d,
                                           input logic [7:0] t, input logic [1:0] w);
        frame_t     f;
        logic [7:0] chk;
        f[0] = 8'hA5;
        f[1] = {2'b00, a};
        f[2] = {2'b00, b};
        f[3] = {2'b00, c};
        f[4] = {2'b00, d};
        f[5] = t;
        f[6] = {6'b000000, w};
        chk  = 8'h00;
        for (int i = 1; i < 7; i++) chk = chk ^ f[i];
        f[7] = chk;
        return f;
    endfunction

    // Line level of frame bit bp (10 bits per byte: start, d0..d7, stop).
    function automatic logic exp_line(input frame_t f, input int bp);
        int by;
        int pos;
        by  = bp / 10;
        pos = bp % 10;
        if (pos == 0) return 1'b0;
        else if (pos == 9) return 1'b1;
        else return f[by][pos-1];
    endfunction

    task automatic set_start(input logic v);
        if (use2) start2 = v;
        else start16 = v;
    endtask

    task automatic rand_inputs();
        in_p1     = 6'($urandom_range(0, 63));
        in_p2     = 6'($urandom_range(0, 63));
        in_p3     = 6'($urandom_range(0, 63));
        in_p4     = 6'($urandom_range(0, 63));
        in_total  = 8'($urandom_range(0, 255));
        in_winner = 2'($urandom_range(0, 3));
    endtask

    function automatic frame_t cur_model();
        return model_frame(in_p1, in_p2, in_p3, in_p4, in_total, in_winner);
    endfunction

    // Caller raises start at a negedge; k=0 is the negedge right after the accept edge.
    task automatic watch_frame(input string tag, input int c, input frame_t exp,
                               input bit hold, input int zero_at);
        int         n;
        int         wave_err;
        int         busy_cnt;
        int         done_cnt;
        int         end_err;
        int         bp;
        logic [7:0] dec [8];
        n = 80 * c;
        wave_err = 0; busy_cnt = 0; done_cnt = 0; end_err = 0;
        for (int j = 0; j < 8; j++) dec[j] = 8'h00;
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clk);
            if (m_busy === 1'b1) busy_cnt++;
            if (m_done === 1'b1) done_cnt++;
            if (k < n) begin
                if (m_tx !== exp_line(exp, k / c)) wave_err++;
                if ((k % c) == (c / 2)) begin
                    bp = k / c;
                    if ((bp % 10) >= 1 && (bp % 10) <= 8) dec[bp/10][(bp%10)-1] = m_tx;
                end
            end else if (k == n) begin
                if (m_done !== 1'b1 || m_tx !== 1'b1 || m_busy !== 1'b0) end_err++;
            end else begin
                if (m_done !== 1'b0 || m_tx !== 1'b1 || m_busy !== 1'b0) end_err++;
            end
            if (k == zero_at) begin
                in_p1 = 6'd0; in_p2 = 6'd0; in_p3 = 6'd0; in_p4 = 6'd0;
                in_total = 8'd0; in_winner = 2'd0;
            end
            if (!hold) begin
                if (k < n) set_start(1'($urandom_range(0, 1)));
                else if (k == n) set_start(1'b1);
                else set_start(1'b0);
            end
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (dec[j] !== exp[j]) begin
                failures++;
                $display("FAIL %s byte%0d: got %h expected %h", tag, j, dec[j], exp[j]);
            end
        end
        checks++;
        if (wave_err !== 0) begin
            failures++;
            $display("FAIL %s waveform: %0d bad cycles, expected 0", tag, wave_err);
        end
        checks++;
        if (busy_cnt !== n) begin
            failures++;
            $display("FAIL %s busy_len: got %0d expected %0d", tag, busy_cnt, n);
        end
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d expected 1", tag, done_cnt);
        end
        checks++;
        if (end_err !== 0) begin
            failures++;
            $display("FAIL %s frame_end: %0d bad end cycles, expected 0", tag, end_err);
        end
    endtask

    task automatic test_reset();
        int bad;
        use2 = 1'b0; start16 = 1'b0; start2 = 1'b0;
        in_p1 = 6'd0; in_p2 = 6'd0; in_p3 = 6'd0; in_p4 = 6'd0;
        in_total = 8'd0; in_winner = 2'd0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if16.tx, if16.busy, if16.done, if2.tx, if2.busy, if2.done} !== 6'b100100) begin
            failures++;
            $display("FAIL reset_state: got %b expected 100100",
                     {if16.tx, if16.busy, if16.done, if2.tx, if2.busy, if2.done});
        end
        reset = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if ({if16.tx, if16.busy, if16.done, if2.tx, if2.busy, if2.done} !== 6'b100100) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL idle_200: %0d non-idle cycles, expected 0", bad);
        end
    endtask

    task automatic test_basic();
        in_p1 = 6'd5; in_p2 = 6'd3; in_p3 = 6'd9; in_p4 = 6'd1;
        in_total = 8'd18; in_winner = 2'd2;
        @(negedge clk);
        start16 = 1'b1;
        watch_frame("basic", 16, cur_model(), 1'b0, -1);
    endtask

    task automatic test_snapshot();
        frame_t exp;
        in_p1 = 6'd5; in_p2 = 6'd3; in_p3 = 6'd9; in_p4 = 6'd1;
        in_total = 8'd18; in_winner = 2'd2;
        exp = cur_model();
        @(negedge clk);
        start16 = 1'b1;
        watch_frame("snapshot", 16, exp, 1'b0, 30 * 16);
    endtask

    task automatic test_back_to_back();
        rand_inputs();
        @(negedge clk);
        start16 = 1'b1;
        for (int f = 0; f < 3; f++) begin
            watch_frame("back_to_back", 16, cur_model(), 1'b1, -1);
            rand_inputs();
        end
        start16 = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        rand_inputs();
        @(negedge clk);
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (43 * 16 + 3) @(negedge clk);
        checks++;
        if (m_busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre_busy: got %b expected 1", m_busy);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_tx, m_busy, m_done} !== 3'b100) begin
            failures++;
            $display("FAIL abort_state: got %b expected 100", {m_tx, m_busy, m_done});
        end
        reset = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({m_tx, m_busy, m_done} !== 3'b100) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL abort_quiet: %0d non-idle cycles, expected 0", bad);
        end
        rand_inputs();
        start16 = 1'b1;
        watch_frame("after_abort", 16, cur_model(), 1'b0, -1);
    endtask

    task automatic test_extremes();
        use2 = 1'b1;
        in_p1 = 6'd63; in_p2 = 6'd63; in_p3 = 6'd63; in_p4 = 6'd63;
        in_total = 8'd255; in_winner = 2'd3;
        @(negedge clk);
        start2 = 1'b1;
        watch_frame("extreme", 2, cur_model(), 1'b0, -1);
        for (int r = 0; r < 4; r++) begin
            rand_inputs();
            start2 = 1'b1;
            watch_frame("random_c2", 2, cur_model(), 1'b0, -1);
        end
        use2 = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 2; r++) begin
            rand_inputs();
            @(negedge clk);
            start16 = 1'b1;
            watch_frame("random_c16", 16, cur_model(), 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_snapshot();
        test_back_to_back();
        test_reset_mid_frame();
        test_extremes();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/evm_result_uart_tx.md
Name: evm_result_uart_tx

Overview:
Result-reporting transmitter for the EVM. On a start request it snapshots the four party vote counts, the total vote count and the winner code. It then transmits them as a fixed 8-byte framed packet over a UART 8N1 serial line to an external display or logging host. It sits downstream of the vote counter and is the outbound end of the result interface.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range 2..65535.
HEADER, 8'hA5, first byte of every frame.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
start  input  1  request to send one result frame; sampled each clk edge
vote_party1  input  6  party 1 vote count
vote_party2  input  6  party 2 vote count
vote_party3  input  6  party 3 vote count
vote_party4  input  6  party 4 vote count
total_voting  input  8  total votes cast
winner  input  2  winning party index (0 = party1 .. 3 = party4)
tx  output  1  UART serial line, idle high
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset: one clk, reset sampled low, synchronous and active-low. Effects:
  - tx=1, busy=0, done=0.
  - State goes to IDLE; bit counter, byte index and baud counter go to 0; snapshot registers clear.
  - Reset mid-frame aborts immediately. tx returns high at that edge; no partial-byte completion and no done pulse.
- Frame content: 8 bytes, sent in this order:
  - B0 = HEADER
  - B1 = {2'b00, vote_party1}
  - B2 = {2'b00, vote_party2}
  - B3 = {2'b00, vote_party3}
  - B4 = {2'b00, vote_party4}
  - B5 = total_voting
  - B6 = {6'b0, winner}
  - B7 = XOR of B1..B6; HEADER is excluded from the checksum.
- Snapshot: all inputs are registered at the edge where start is accepted. Later input changes do not affect the frame in flight. Checksum is computed from the snapshot.
- Accept: start=1 while in IDLE is accepted at that edge.
  - busy=1 from that edge.
  - tx=0 (start bit of B0) from that same edge.
- start while busy=1 is ignored; it is neither queued nor restarts the frame.
- Byte format: 8N1, LSB first.
  - Start bit 0, then data bits d0..d7, then stop bit 1.
  - Each bit holds for exactly CLKS_PER_BIT cycles.
- No inter-byte gap: the start bit of byte k+1 follows the stop bit of byte k directly.
- Frame length: 80*CLKS_PER_BIT cycles from accept to the end of the B7 stop bit.
- State machine: IDLE -> START_BIT -> DATA_BITS (8 bits) -> STOP_BIT.
  - From STOP_BIT: go to START_BIT if byte index < 7, otherwise DONE.
  - DONE -> IDLE after one cycle.
- End of frame, at the edge ending the B7 stop bit:
  - done=1 for exactly one cycle, busy=0 and tx=1.
  - The FSM is in DONE that cycle.
  - start asserted during the DONE cycle is ignored.
  - A new start is accepted from the following cycle (IDLE) onward.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps, width $clog2(CLKS_PER_BIT). Byte index is 3 bits, bit index is 3 bits.
- Boundary values: counts of 0 or 63 and total_voting of 255 are sent unmodified. There is no saturation or range checking; the block does not check that total equals the sum of the party counts.
- Glitch-free output: tx is driven from a register only.

Test Plan:
1. Reset hold then release with start=0 for 200 cycles -> tx=1, busy=0, done=0 throughout.
2. CLKS_PER_BIT=16, inputs P1=5, P2=3, P3=9, P4=1, total=18, winner=2, single start pulse. Required response:
   - The decoded bytes are A5, 05, 03, 09, 01, 12, 02, 1E.
   - busy is high for exactly 1280 cycles.
   - done pulses once at cycle 1280 after accept.
   - Each bit is 16 cycles wide.
3. Inputs changed to all 0 mid-frame (after B2) -> the remaining bytes still match the scenario 2 snapshot; the checksum is 1E.
4. start held high continuously for 3000 cycles -> back-to-back frames, each separated by exactly one DONE cycle plus the re-accept edge. Each frame is correct and done pulses once per frame.
5. Reset asserted during the DATA_BITS state of B4 -> tx=1 and busy=0 at the next edge, with no done pulse. A later start sends a complete, fresh frame.
6. Extremes P1=P2=P3=P4=63, total=255, winner=3, with CLKS_PER_BIT=2 -> bytes A5, 3F, 3F, 3F, 3F, FF, 03, FC; frame length is 160 cycles.
